// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide RAM/IO port between instruction fetch
// (4-byte reads) and the load/store unit (1/2/4-byte reads and writes).
// Requests are split into per-byte RAM cycles; read bytes are reassembled
// little-endian and returned with a one-cycle done pulse.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | arbitrate, LS over fetch; accept latches address/len/data
//   READ    | issue len addresses, capture bytes one cycle later, pulse done
//   WRITE   | drive one byte per cycle, hold while the IO buffer is full
//
// A read stays in READ for its done cycle, so a requester can never be
// re-accepted in the cycle its own done is visible. A write drops to IDLE
// as its done appears; the done-high ignore rule in IDLE covers that case.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [1:0]  IO_SEL     = 2'b11
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  clear_in,
  input  logic                  if_req_in,
  input  logic [ADDR_WIDTH-1:0] if_addr_in,
  output logic                  if_done_out,
  output logic [DATA_WIDTH-1:0] if_data_out,
  input  logic                  ls_req_in,
  input  logic                  ls_wr_in,
  input  logic [ADDR_WIDTH-1:0] ls_addr_in,
  input  logic [2:0]            ls_len_in,
  input  logic [DATA_WIDTH-1:0] ls_data_in,
  output logic                  ls_done_out,
  output logic [DATA_WIDTH-1:0] ls_data_out,
  input  logic [7:0]            mem_din_in,
  output logic [7:0]            mem_dout_out,
  output logic [ADDR_WIDTH-1:0] mem_a_out,
  output logic                  mem_wr_out,
  input  logic                  io_buffer_full_in
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_e;
  typedef enum logic {OWN_FETCH, OWN_LS} owner_e;

  state_e                state_q;
  owner_e                owner_q;
  logic [2:0]            cnt_q;
  logic [2:0]            len_q;
  logic [31:0]           wdata_q;
  logic [31:0]           buf_q;
  logic                  if_done_q;
  logic                  ls_done_q;
  logic [DATA_WIDTH-1:0] if_data_q;
  logic [DATA_WIDTH-1:0] ls_data_q;
  logic [ADDR_WIDTH-1:0] mem_a_q;
  logic [7:0]            mem_dout_q;
  logic                  mem_wr_q;

  logic [2:0]            ls_len_dec;
  logic                  if_go;
  logic                  ls_go;
  logic [2:0]            cnt_inc_d;
  logic [1:0]            cap_lane_d;
  logic [31:0]           buf_d;
  logic [ADDR_WIDTH-1:0] mem_a_inc_d;
  logic [7:0]            wr_next_byte_d;
  logic                  stall_accept;
  logic                  stall_cur;
  logic                  stall_next;

  // Byte count decode: anything other than 1 or 2 is a word access.
  always_comb begin
    ls_len_dec = 3'd4;
    if (ls_len_in == 3'd1)      ls_len_dec = 3'd1;
    else if (ls_len_in == 3'd2) ls_len_dec = 3'd2;
  end

  // A requester whose done is showing this cycle is still dropping its request.
  assign if_go = if_req_in && !if_done_q;
  assign ls_go = ls_req_in && !ls_done_q;

  assign cnt_inc_d   = cnt_q + 3'd1;
  assign mem_a_inc_d = mem_a_q + ADDR_WIDTH'(1);

  // In READ, cnt_q == k+1 while byte k is on mem_din_in.
  assign cap_lane_d = cnt_q[1:0] - 2'd1;
  assign buf_d      = buf_q | (32'(mem_din_in) << {cap_lane_d, 3'b000});

  assign wr_next_byte_d = wdata_q[{cnt_inc_d[1:0], 3'b000} +: 8];

  // IO stall is decided one cycle ahead so mem_wr_out can stay registered.
  assign stall_accept = (ls_addr_in[17:16] == IO_SEL) && io_buffer_full_in;
  assign stall_cur    = (mem_a_q[17:16] == IO_SEL) && io_buffer_full_in;
  assign stall_next   = (mem_a_inc_d[17:16] == IO_SEL) && io_buffer_full_in;

  // Sequencer: arbitration, byte stepping and all registered outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_FETCH;
      cnt_q      <= '0;
      len_q      <= '0;
      wdata_q    <= '0;
      buf_q      <= '0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_data_q  <= '0;
      ls_data_q  <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
    end else if (rdy_in) begin
      case (state_q)
        S_IDLE: begin
          if_done_q <= 1'b0;
          ls_done_q <= 1'b0;
          mem_wr_q  <= 1'b0;
          if (!clear_in && (ls_go || if_go)) begin
            cnt_q <= '0;
            buf_q <= '0;
            if (ls_go) begin
              owner_q <= OWN_LS;
              len_q   <= ls_len_dec;
              wdata_q <= ls_data_in[31:0];
              mem_a_q <= ls_addr_in;
              if (ls_wr_in) begin
                state_q    <= S_WRITE;
                mem_dout_q <= ls_data_in[7:0];
                mem_wr_q   <= !stall_accept;
              end else begin
                state_q <= S_READ;
              end
            end else begin
              owner_q <= OWN_FETCH;
              len_q   <= 3'd4;
              mem_a_q <= if_addr_in;
              state_q <= S_READ;
            end
          end
        end

        S_READ: begin
          if (if_done_q || ls_done_q) begin
            if_done_q <= 1'b0;
            ls_done_q <= 1'b0;
            state_q   <= S_IDLE;
          end else if (clear_in) begin
            state_q <= S_IDLE;
          end else begin
            if (cnt_q != 3'd0) buf_q <= buf_d;
            if (cnt_q == len_q) begin
              if (owner_q == OWN_LS) begin
                ls_done_q <= 1'b1;
                ls_data_q <= DATA_WIDTH'(buf_d);
              end else begin
                if_done_q <= 1'b1;
                if_data_q <= DATA_WIDTH'(buf_d);
              end
            end else begin
              cnt_q <= cnt_inc_d;
              if (cnt_inc_d < len_q) mem_a_q <= mem_a_inc_d;
            end
          end
        end

        S_WRITE: begin
          // Stores are committed: a flush does not interrupt them.
          if (mem_wr_q) begin
            if (cnt_inc_d == len_q) begin
              ls_done_q <= 1'b1;
              mem_wr_q  <= 1'b0;
              state_q   <= S_IDLE;
            end else begin
              cnt_q      <= cnt_inc_d;
              mem_a_q    <= mem_a_inc_d;
              mem_dout_q <= wr_next_byte_d;
              mem_wr_q   <= !stall_next;
            end
          end else begin
            mem_wr_q <= !stall_cur;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign if_done_out  = if_done_q;
  assign if_data_out  = if_data_q;
  assign ls_done_out  = ls_done_q;
  assign ls_data_out  = ls_data_q;
  assign mem_a_out    = mem_a_q;
  assign mem_dout_out = mem_dout_q;
  assign mem_wr_out   = mem_wr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Cycle 0 is the cycle in which a request
// is first presented; outputs are sampled 1 ns after each rising edge.
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear_in;
  logic        if_req_in;
  logic [31:0] if_addr_in;
  logic        if_done_out;
  logic [31:0] if_data_out;
  logic        ls_req_in;
  logic        ls_wr_in;
  logic [31:0] ls_addr_in;
  logic [2:0]  ls_len_in;
  logic [31:0] ls_data_in;
  logic        ls_done_out;
  logic [31:0] ls_data_out;
  logic [7:0]  mem_din_in;
  logic [7:0]  mem_dout_out;
  logic [31:0] mem_a_out;
  logic        mem_wr_out;
  logic        io_buffer_full_in;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] ram [0:65535];
  logic [7:0] sw_bytes [4];
  logic [31:0] wrap_addr [4];

  always #5 clk_in = ~clk_in;

  // Synchronous read-only RAM; it shares the global ready with the arbiter.
  always @(posedge clk_in)
    if (rdy_in) mem_din_in <= ram[mem_a_out[15:0]];

  mem_arbiter dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .clear_in          (clear_in),
    .if_req_in         (if_req_in),
    .if_addr_in        (if_addr_in),
    .if_done_out       (if_done_out),
    .if_data_out       (if_data_out),
    .ls_req_in         (ls_req_in),
    .ls_wr_in          (ls_wr_in),
    .ls_addr_in        (ls_addr_in),
    .ls_len_in         (ls_len_in),
    .ls_data_in        (ls_data_in),
    .ls_done_out       (ls_done_out),
    .ls_data_out       (ls_data_out),
    .mem_din_in        (mem_din_in),
    .mem_dout_out      (mem_dout_out),
    .mem_a_out         (mem_a_out),
    .mem_wr_out        (mem_wr_out),
    .io_buffer_full_in (io_buffer_full_in)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h1000] = 8'h13; ram[16'h1001] = 8'h05;
    ram[16'h1002] = 8'h10; ram[16'h1003] = 8'h00;
    ram[16'h2001] = 8'hAA; ram[16'h2002] = 8'hBB; ram[16'h2003] = 8'hCC;
    ram[16'hFFFE] = 8'h11; ram[16'hFFFF] = 8'h22;
    ram[16'h0000] = 8'h33; ram[16'h0001] = 8'h44;
    sw_bytes  = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    wrap_addr = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

    rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
    if_req_in = 1'b0; if_addr_in = '0;
    ls_req_in = 1'b0; ls_wr_in = 1'b0; ls_addr_in = '0; ls_len_in = '0; ls_data_in = '0;
    io_buffer_full_in = 1'b0;
    #2;
    chk_eq("rst_if_done", 32'(if_done_out), 32'd0);
    chk_eq("rst_ls_done", 32'(ls_done_out), 32'd0);
    chk_eq("rst_mem_a",   mem_a_out, 32'd0);
    chk_eq("rst_mem_wr",  32'(mem_wr_out), 32'd0);
    chk_eq("rst_dout",    32'(mem_dout_out), 32'd0);
    chk_eq("rst_if_data", if_data_out, 32'd0);
    tick(); tick();
    #2 rst_in = 1'b1;

    // Fetch of one word at 0x1000.
    tick();
    if_req_in = 1'b1; if_addr_in = 32'h1000;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c <= 4) chk_eq("fetch_addr", mem_a_out, 32'h1000 + 32'(c - 1));
      if (c == 1) chk_eq("fetch_wr", 32'(mem_wr_out), 32'd0);
      chk_eq("fetch_done", 32'(if_done_out), 32'(c == 6));
      if (c == 6) begin
        chk_eq("fetch_data", if_data_out, 32'h0010_0513);
        if_req_in = 1'b0;
      end
    end

    // Simultaneous requests: LS half-word read wins, fetch follows.
    tick();
    if_req_in = 1'b1; if_addr_in = 32'h1000;
    ls_req_in = 1'b1; ls_wr_in = 1'b0; ls_addr_in = 32'h2001; ls_len_in = 3'd2;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) chk_eq("arb_addr1", mem_a_out, 32'h2001);
      if (c == 2) chk_eq("arb_addr2", mem_a_out, 32'h2002);
      chk_eq("arb_ls_done", 32'(ls_done_out), 32'(c == 4));
      if (c == 4) begin
        chk_eq("arb_ls_data", ls_data_out, 32'h0000_BBAA);
        ls_req_in = 1'b0;
      end
      if (c == 5) chk_eq("arb_no_early_fetch", mem_a_out, 32'h2002);
      if (c == 6) chk_eq("arb_fetch_addr", mem_a_out, 32'h1000);
      chk_eq("arb_if_done", 32'(if_done_out), 32'(c == 11));
      if (c == 11) begin
        chk_eq("arb_if_data", if_data_out, 32'h0010_0513);
        if_req_in = 1'b0;
      end
    end

    // Byte store to IO while the output buffer is full for three cycles.
    tick();
    ls_req_in = 1'b1; ls_wr_in = 1'b1; ls_addr_in = 32'h0003_0000; ls_len_in = 3'd1;
    ls_data_in = 32'h1234_5641; io_buffer_full_in = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk_eq("io_wr", 32'(mem_wr_out), 32'(c == 4));
      if (c == 4) begin
        chk_eq("io_dout", 32'(mem_dout_out), 32'h41);
        chk_eq("io_addr", mem_a_out, 32'h0003_0000);
      end
      chk_eq("io_done", 32'(ls_done_out), 32'(c == 5));
      if (c == 3) io_buffer_full_in = 1'b0;
      if (c == 5) begin ls_req_in = 1'b0; ls_wr_in = 1'b0; end
    end

    // Flush in cycle 3 of a fetch; clear held into the idle cycle.
    tick();
    if_req_in = 1'b1; if_addr_in = 32'h1000;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk_eq("flush_if_done", 32'(if_done_out), 32'd0);
      if (c == 3) begin
        chk_eq("flush_addr3", mem_a_out, 32'h1002);
        clear_in = 1'b1;
      end
      if (c == 5) begin
        chk_eq("flush_no_accept", mem_a_out, 32'h1002);
        clear_in = 1'b0; if_req_in = 1'b0;
      end
    end

    // Word store with a flush in the middle: it completes anyway.
    tick();
    ls_req_in = 1'b1; ls_wr_in = 1'b1; ls_addr_in = 32'h100; ls_len_in = 3'd4;
    ls_data_in = 32'hDEAD_BEEF;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c <= 4) begin
        chk_eq("sw_wr",   32'(mem_wr_out), 32'd1);
        chk_eq("sw_addr", mem_a_out, 32'h100 + 32'(c - 1));
        chk_eq("sw_dout", 32'(mem_dout_out), 32'(sw_bytes[c-1]));
      end
      chk_eq("sw_done", 32'(ls_done_out), 32'(c == 5));
      if (c == 2) clear_in = 1'b1;
      if (c == 3) clear_in = 1'b0;
      if (c == 5) begin
        chk_eq("sw_wr_end", 32'(mem_wr_out), 32'd0);
        ls_req_in = 1'b0; ls_wr_in = 1'b0;
      end
    end

    // Freeze for two cycles mid-fetch, then once more in the done cycle.
    tick();
    if_req_in = 1'b1; if_addr_in = 32'h1000;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c >= 2 && c <= 4) chk_eq("frz_hold_addr", mem_a_out, 32'h1001);
      if (c == 5) chk_eq("frz_addr5", mem_a_out, 32'h1002);
      if (c == 6) chk_eq("frz_addr6", mem_a_out, 32'h1003);
      chk_eq("frz_done", 32'(if_done_out), 32'(c == 8 || c == 9));
      if (c == 2) rdy_in = 1'b0;
      if (c == 4) rdy_in = 1'b1;
      if (c == 8) begin
        chk_eq("frz_data", if_data_out, 32'h0010_0513);
        rdy_in = 1'b0;
      end
      if (c == 9) begin rdy_in = 1'b1; if_req_in = 1'b0; end
    end

    // Illegal length 3 is a word; address wraps past the top.
    tick();
    ls_req_in = 1'b1; ls_wr_in = 1'b0; ls_addr_in = 32'hFFFF_FFFE; ls_len_in = 3'd3;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c <= 4) chk_eq("wrap_addr", mem_a_out, wrap_addr[c-1]);
      chk_eq("wrap_done", 32'(ls_done_out), 32'(c == 6));
      if (c == 6) begin
        chk_eq("wrap_data", ls_data_out, 32'h4433_2211);
        ls_req_in = 1'b0;
      end
    end

    // Asynchronous reset in the middle of a store.
    tick();
    ls_req_in = 1'b1; ls_wr_in = 1'b1; ls_addr_in = 32'h100; ls_len_in = 3'd4;
    ls_data_in = 32'hCAFE_F00D;
    tick();
    tick();
    chk_eq("rstw_pre_wr", 32'(mem_wr_out), 32'd1);
    #2 rst_in = 1'b0;
    #1;
    chk_eq("rstw_wr",      32'(mem_wr_out), 32'd0);
    chk_eq("rstw_addr",    mem_a_out, 32'd0);
    chk_eq("rstw_dout",    32'(mem_dout_out), 32'd0);
    chk_eq("rstw_ls_data", ls_data_out, 32'd0);
    chk_eq("rstw_if_data", if_data_out, 32'd0);
    chk_eq("rstw_ls_done", 32'(ls_done_out), 32'd0);
    ls_req_in = 1'b0; ls_wr_in = 1'b0;
    tick();
    #2 rst_in = 1'b1;
    tick();
    tick();
    chk_eq("rstw_idle_wr", 32'(mem_wr_out), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single byte-wide RAM/IO port.
- Shares the port between two requesters:
  - instruction fetch: 4-byte reads;
  - load/store controller: 1/2/4-byte reads and writes.
- Splits each request into per-byte RAM cycles, reassembles read data little-endian and returns it with a one-cycle done pulse.
- Sits between the fetch unit, the load/store controller and the top-level memory pins.

Parameters:
ADDR_WIDTH, 32, address width of requests and RAM port
DATA_WIDTH, 32, request data width
IO_SEL, 2'b11, value of addr[17:16] that marks the IO region

Ports:
clk_in  input  1  clock; all state updates on rising edge
rst_in  input  1  reset, asynchronous, active-low
rdy_in  input  1  global ready; when low all state and outputs hold
clear_in  input  1  pipeline flush (ROB refresh)
if_req_in  input  1  fetch request, level, held until if_done_out
if_addr_in  input  ADDR_WIDTH  fetch address (4-byte read)
if_done_out  output  1  one-cycle completion pulse to fetch
if_data_out  output  DATA_WIDTH  fetched word, valid with if_done_out
ls_req_in  input  1  load/store request, level, held until ls_done_out
ls_wr_in  input  1  1 = write, 0 = read
ls_addr_in  input  ADDR_WIDTH  byte address
ls_len_in  input  3  byte count: 1, 2 or 4
ls_data_in  input  DATA_WIDTH  store data; low ls_len_in bytes used
ls_done_out  output  1  one-cycle completion pulse to load/store controller
ls_data_out  output  DATA_WIDTH  load data, zero-extended, valid with ls_done_out
mem_din_in  input  8  RAM read byte; valid one cycle after its address
mem_dout_out  output  8  RAM write byte
mem_a_out  output  ADDR_WIDTH  RAM address
mem_wr_out  output  1  1 = write this cycle
io_buffer_full_in  input  1  IO output buffer full

Behaviour:
Reset (rst_in low, asynchronous):
- state IDLE, byte counter 0.
- All done outputs 0; all data outputs 0.
- mem_a_out 0, mem_dout_out 0, mem_wr_out 0.

Freeze:
- rdy_in low: no state, counter or output changes.
- Done pulses are extended while rdy_in is low.

States: IDLE, READ, WRITE.
- Owner register: FETCH or LS.
- Byte counter cnt: 0..4.
- Latched addr, len, wdata; 32-bit read assembly buffer.

IDLE:
- Arbitration priority: LS over fetch, fixed.
- A requester whose done output is high in the current cycle is ignored.
- If clear_in is high, no request is accepted that cycle.
- On accept: latch fields; fetch len = 4, write = 0.
- LS write -> WRITE. LS read or fetch -> READ.
- mem_wr_out = 0 while IDLE.

READ:
- Cycles c = 1..len after accept: drive mem_a_out = addr + (c-1), mem_wr_out = 0.
- Byte k is captured from mem_din_in in cycle k+2 into bits [8k+7:8k].
- After the last byte is captured: done pulse plus data in cycle len+2 relative to the accept cycle 0, and return to IDLE.
- Unused upper bytes are 0.

WRITE:
- Cycle c drives mem_a_out = addr + (c-1), mem_dout_out = byte c-1, mem_wr_out = 1.
- ls_done_out is high in cycle len+1, then IDLE.
- IO stall: if addr[17:16] == IO_SEL and io_buffer_full_in is high, drive mem_wr_out = 0 and do not advance cnt. Resume when io_buffer_full_in drops.

Address arithmetic:
- addr + k wraps modulo 2^ADDR_WIDTH.
- No alignment requirement; misaligned accesses are performed bytewise.

Flush (clear_in high at an edge with rdy_in high):
- Owner FETCH, or LS read: abort to IDLE. No done pulse; a done that would have fired on that edge is suppressed.
- LS write: continue to completion and pulse ls_done_out normally (committed store).

Illegal ls_len_in (0, 3, 5-7): treated as 4.

Done outputs: registered, high exactly one cycle per completed transaction.

Test Plan:
- Fetch read: if_req_in with addr 0x1000, RAM bytes 0x13,0x05,0x10,0x00 -> if_done_out pulses in cycle 6, if_data_out = 0x00100513; mem_a_out goes 0x1000..0x1003 in cycles 1-4.
- Simultaneous requests: if_req_in and ls_req_in (read, len 2, addr 0x2001) both high in cycle 0 -> LS served first, ls_data_out = 0x0000BBAA in cycle 4; fetch accepted in cycle 5 (its first idle cycle), not in cycle 4 (done-cycle ignore rule for LS; fetch served next).
- Byte store to IO: SB of 0x41 to 0x30000 with io_buffer_full_in high for 3 cycles -> mem_wr_out stays 0 for 3 cycles, then exactly one write cycle with mem_dout_out = 0x41, then ls_done_out.
- Flush during fetch: clear_in in cycle 3 of a fetch -> no if_done_out, IDLE next cycle; a pending if_req_in is not accepted in the clear cycle.
- Flush during SW of 0xDEADBEEF to 0x100 -> all 4 bytes written (0xEF,0xBE,0xAD,0xDE), ls_done_out pulses.
- Reset and freeze: rst_in low mid-WRITE -> outputs return to reset values immediately. rdy_in low for 2 cycles mid-READ -> mem_a_out and cnt hold, done delayed by 2 cycles.
